// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for the accumulator-machine controller.
// Holds the opcode values, the controller state encoding, the accumulator
// source-select codes and the opcode-to-execute-state mapping.
// Used by control_unit and by the datapath bench.
package ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_INPUT = 3'b100,
    OP_JZ    = 3'b101,
    OP_JPOS  = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  typedef enum logic [3:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_STORE,
    S_ADD,
    S_SUB,
    S_INPUT,
    S_JZ,
    S_JPOS,
    S_HALT
  } state_t;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_RAM = 2'b10;

  // Execute state selected by the opcode held in the instruction register.
  function automatic state_t exec_state(input logic [2:0] ir);
    case (ir)
      OP_LOAD:  return S_LOAD;
      OP_STORE: return S_STORE;
      OP_ADD:   return S_ADD;
      OP_SUB:   return S_SUB;
      OP_INPUT: return S_INPUT;
      OP_JZ:    return S_JZ;
      OP_JPOS:  return S_JPOS;
      default:  return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_instr_counter.sv
// instr_counter -- retired-instruction counter.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears the count
//   inc    count one retired instruction on this edge
//   count  current count, wraps from 2^CNT_W-1 to 0
module instr_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit -- FSM controller for a simple accumulator datapath.
// Each instruction runs START, FETCH, DECODE and one execute state; INPUT
// waits in its execute state for the Enter strobe and HALT is terminal until
// reset.
// Ports:
//   Clock, Reset (async active-low)
//   IR[2:0]        opcode from the instruction register, sampled in DECODE
//   Aeq0, Apos     accumulator flags for JZ / JPOS
//   Enter          operator strobe completing INPUT
//   Step           (only with CTRL_SINGLE_STEP_EN) allows START to advance
//   IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Asel[1:0]  datapath controls
//   Halt           high while halted
//   Count          retired-instruction count (CNT_W bits)
// Build option: define CTRL_SINGLE_STEP_EN to add the Step input.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [2:0]       IR,
  input  logic             Aeq0,
  input  logic             Apos,
  input  logic             Enter,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic             Step,
`endif
  output logic             IRload,
  output logic             PCload,
  output logic             JMPmux,
  output logic             Meminst,
  output logic             MemWr,
  output logic             Aload,
  output logic             Sub,
  output logic [1:0]       Asel,
  output logic             Halt,
  output logic [CNT_W-1:0] Count
);

  state_t state;
  logic   go;
  logic   retire;

`ifdef CTRL_SINGLE_STEP_EN
  assign go = Step;
`else
  assign go = 1'b1;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= S_START;
    end else begin
      case (state)
        S_START:  if (go) state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= exec_state(IR);
        S_INPUT:  if (Enter) state <= S_START;
        S_HALT:   state <= S_HALT;
        default:  state <= S_START;
      endcase
    end
  end

  // An instruction retires when its execute state hands back to START;
  // HALT counts as retired on the edge that enters it.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: retire = 1'b1;
      S_INPUT:  retire = Enter;
      S_DECODE: retire = (IR == OP_HALT);
      default:  retire = 1'b0;
    endcase
  end

  always_comb begin
    IRload  = 1'b0;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Asel    = ASEL_ALU;
    Halt    = 1'b0;
    case (state)
      S_FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      S_DECODE: Meminst = 1'b1;
      S_LOAD: begin
        Meminst = 1'b1;
        Asel    = ASEL_RAM;
        Aload   = 1'b1;
      end
      S_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      S_ADD: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
      end
      S_SUB: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
        Sub     = 1'b1;
      end
      S_INPUT: begin
        Asel  = ASEL_IN;
        Aload = Enter;
      end
      S_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      S_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      S_HALT:  Halt = 1'b1;
      default: ;
    endcase
  end

  instr_counter #(
    .CNT_W(CNT_W)
  ) u_instr_counter (
    .clk  (Clock),
    .rst_n(Reset),
    .inc  (retire),
    .count(Count)
  );

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- self-checking bench for control_unit.
// Two instances share stimulus: an 8-bit counter build and a 2-bit counter
// build (for wrap). A per-instruction reference model gives the expected
// control vector for each cycle of an instruction and the expected count.
module tb_control_unit;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [2:0] IR    = 3'b000;
  logic       Aeq0  = 1'b0;
  logic       Apos  = 1'b0;
  logic       Enter = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
  logic       Step  = 1'b0;
`endif

  logic IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [7:0] Count;

  logic b_irload, b_pcload, b_jmpmux, b_meminst, b_memwr, b_aload, b_sub, b_halt;
  logic [1:0] b_asel;
  logic [1:0] Count_b;

  logic [9:0] obs_vec;
  assign obs_vec = {IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Asel, Halt};

  control_unit #(.CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
`ifdef CTRL_SINGLE_STEP_EN
    .Step(Step),
`endif
    .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux), .Meminst(Meminst),
    .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Asel(Asel), .Halt(Halt), .Count(Count)
  );

  control_unit #(.CNT_W(2)) dut_b (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
`ifdef CTRL_SINGLE_STEP_EN
    .Step(Step),
`endif
    .IRload(b_irload), .PCload(b_pcload), .JMPmux(b_jmpmux), .Meminst(b_meminst),
    .MemWr(b_memwr), .Aload(b_aload), .Sub(b_sub), .Asel(b_asel), .Halt(b_halt),
    .Count(Count_b)
  );

  always #5 Clock = ~Clock;

  int n_pass  = 0;
  int n_total = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected {IRload,PCload,JMPmux,Meminst,MemWr,Aload,Sub,Asel[1:0],Halt}
  // for phase 0 START, 1 FETCH, 2 DECODE, 3 execute.
  function automatic logic [9:0] exp_vec(input int phase, input logic [2:0] op,
                                         input logic aeq, input logic apos,
                                         input logic ent);
    case (phase)
      0: return 10'b0000000000;
      1: return 10'b1100000000;
      2: return 10'b0001000000;
      default: begin
        case (op)
          3'd0:    return 10'b0001010100;
          3'd1:    return 10'b0001100000;
          3'd2:    return 10'b0001010000;
          3'd3:    return 10'b0001011000;
          3'd4:    return {5'b00000, ent, 1'b0, 2'b01, 1'b0};
          3'd5:    return {1'b0, aeq, 1'b1, 7'b0000000};
          3'd6:    return {1'b0, apos, 1'b1, 7'b0000000};
          default: return 10'b0000000001;
        endcase
      end
    endcase
  endfunction

  task automatic check_counts(input string tag);
    chk({tag, "_cnt"}, 32'(Count), 32'(exp_cnt % 256));
    chk({tag, "_cnt2"}, 32'(Count_b), 32'(exp_cnt % 4));
  endtask

  // Called just after a rising edge; samples on the falling edge, then
  // returns just after the next rising edge.
  task automatic check_cycle(input string tag, input int phase, input logic [2:0] op,
                             input logic aeq, input logic apos, input logic ent);
    @(negedge Clock);
    chk(tag, 32'(obs_vec), 32'(exp_vec(phase, op, aeq, apos, ent)));
    @(posedge Clock);
    #1;
  endtask

  // Runs one instruction starting in the START cycle.
  task automatic run_instr(input logic [2:0] op, input int nwait,
                           input logic aeq, input logic apos);
    IR   = op;
    Aeq0 = 1'($urandom);
    Apos = 1'($urandom);
`ifdef CTRL_SINGLE_STEP_EN
    Step = 1'b1;
`endif
    @(negedge Clock);
    check_counts("start");
    @(posedge Clock);
    #1;
    chk("start_vec_prev", 32'(obs_vec), 32'(exp_vec(1, op, 1'b0, 1'b0, 1'b0)));
`ifdef CTRL_SINGLE_STEP_EN
    Step = 1'b0;
`endif
    check_cycle("fetch", 1, op, 1'b0, 1'b0, 1'b0);
    check_cycle("decode", 2, op, 1'b0, 1'b0, 1'b0);
    IR = 3'($urandom);
    if (op == 3'd4) begin
      for (int i = 0; i <= nwait; i++) begin
        Enter = (i == nwait);
        check_cycle("input", 3, op, 1'b0, 1'b0, Enter);
      end
      Enter = 1'b0;
      exp_cnt++;
    end else if (op == 3'd7) begin
      exp_cnt++;
      for (int i = 0; i < 20; i++) begin
        Enter = 1'($urandom);
        @(negedge Clock);
        chk("halt_vec", 32'(obs_vec), 32'(exp_vec(3, op, 1'b0, 1'b0, 1'b0)));
        check_counts("halt");
        @(posedge Clock);
        #1;
      end
    end else begin
      Aeq0 = aeq;
      Apos = apos;
      check_cycle("exec", 3, op, aeq, apos, 1'b0);
      exp_cnt++;
    end
  endtask

  initial begin
    logic [2:0] op;
    #1;
    chk("rst_vec", 32'(obs_vec), 32'd0);
    check_counts("rst");
    @(posedge Clock);
    #1;
    Reset = 1'b1;

`ifdef CTRL_SINGLE_STEP_EN
    Step = 1'b0;
    for (int i = 0; i < 10; i++) check_cycle("step_hold", 0, 3'd0, 1'b0, 1'b0, 1'b0);
    run_instr(3'd2, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("step_idle_vec", 32'(obs_vec), 32'd0);
      check_counts("step_idle");
      @(posedge Clock);
      #1;
    end
`endif

    // LOAD as the first instruction, then directed jumps, ADD run, INPUT wait.
    run_instr(3'd0, 0, 1'b0, 1'b0);
    run_instr(3'd5, 0, 1'b1, 1'b0);
    run_instr(3'd5, 0, 1'b0, 1'b1);
    run_instr(3'd6, 0, 1'b0, 1'b1);
    run_instr(3'd6, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) run_instr(3'd2, 0, 1'b0, 1'b0);
    run_instr(3'd3, 0, 1'b0, 1'b0);
    run_instr(3'd1, 0, 1'b0, 1'b0);
    run_instr(3'd4, 5, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 6));
      run_instr(op, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    // HALT, then asynchronous reset in the middle of a clock phase.
    run_instr(3'd7, 0, 1'b0, 1'b0);
    #3;
    Reset = 1'b0;
    #1;
    exp_cnt = 0;
    chk("halt_rst_vec", 32'(obs_vec), 32'd0);
    check_counts("halt_rst");
    @(posedge Clock);
    #1;
    chk("rst_hold_vec", 32'(obs_vec), 32'd0);
    Reset = 1'b1;

    run_instr(3'd2, 0, 1'b0, 1'b0);
    run_instr(3'd4, 0, 1'b0, 1'b0);
    run_instr(3'd7, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
